// File: rtl/muldiv_if.sv
// E-stage multiply/divide request bundle between the pipeline and muldiv_ctrl.
// The pipeline side drives requests (master); muldiv_ctrl answers with busy/stall/HI/LO (slave).
interface muldiv_if;
  logic [2:0]  md_op;
  logic        md_start;
  logic        md_cancel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_req_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, md_start, md_cancel, rs_data, rt_data, md_req_d,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  md_op, md_start, md_cancel, rs_data, rt_data, md_req_d,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the E stage: HI/LO, fixed-latency busy window, D-stage stall.
// Define MULDIV_MADD_EN to enable op 7 (madd: {hi,lo} += signed rs * signed rt).
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  muldiv_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [63:0]      pend_reg, pend_next;
  logic             pend_ok_reg, pend_ok_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;

  logic        busy;
  logic        accept;
  logic        long_op;
  logic        long_start;

  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic        [63:0] prod_u;

  logic        div_zero;
  logic [31:0] dvd_abs, dvs_abs, dvs_abs_safe, dvs_u_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign busy   = (state_reg == ST_BUSY);
  assign accept = md.md_start & ~md.md_cancel & ~busy;

  always_comb begin
    long_op = 1'b0;
    case (md.md_op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  assign long_start = md.md_start & ~md.md_cancel & long_op;

  // Full-width sign extension keeps the 64-bit product exact without relying on context sizing.
  assign rs_sx  = {{32{md.rs_data[31]}}, md.rs_data};
  assign rt_sx  = {{32{md.rt_data[31]}}, md.rt_data};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, md.rs_data} * {32'd0, md.rt_data};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
  assign div_zero     = (md.rt_data == 32'd0);
  assign dvd_abs      = md.rs_data[31] ? -md.rs_data : md.rs_data;
  assign dvs_abs      = md.rt_data[31] ? -md.rt_data : md.rt_data;
  assign dvs_abs_safe = div_zero ? 32'd1 : dvs_abs;
  assign dvs_u_safe   = div_zero ? 32'd1 : md.rt_data;
  assign q_mag        = dvd_abs / dvs_abs_safe;
  assign r_mag        = dvd_abs % dvs_abs_safe;
  assign q_s          = (md.rs_data[31] ^ md.rt_data[31]) ? -q_mag : q_mag;
  assign r_s          = md.rs_data[31] ? -r_mag : r_mag;
  assign q_u          = md.rs_data / dvs_u_safe;
  assign r_u          = md.rs_data % dvs_u_safe;

`ifdef MULDIV_MADD_EN
  logic [63:0] madd_sum;
  assign madd_sum = {hi_reg, lo_reg} + $unsigned(prod_s);
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_next    = pend_reg;
    pend_ok_next = pend_ok_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (md.md_op)
            OP_MULT: begin
              pend_next    = $unsigned(prod_s);
              pend_ok_next = 1'b1;
              cnt_next     = CNT_W'(MULT_CYCLES);
              state_next   = ST_BUSY;
            end
            OP_MULTU: begin
              pend_next    = prod_u;
              pend_ok_next = 1'b1;
              cnt_next     = CNT_W'(MULT_CYCLES);
              state_next   = ST_BUSY;
            end
            OP_DIV: begin
              pend_next    = {r_s, q_s};
              pend_ok_next = ~div_zero;
              cnt_next     = CNT_W'(DIV_CYCLES);
              state_next   = ST_BUSY;
            end
            OP_DIVU: begin
              pend_next    = {r_u, q_u};
              pend_ok_next = ~div_zero;
              cnt_next     = CNT_W'(DIV_CYCLES);
              state_next   = ST_BUSY;
            end
            OP_MTHI: hi_next = md.rs_data;
            OP_MTLO: lo_next = md.rs_data;
`ifdef MULDIV_MADD_EN
            OP_MADD: begin
              pend_next    = madd_sum;
              pend_ok_next = 1'b1;
              cnt_next     = CNT_W'(MULT_CYCLES);
              state_next   = ST_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          // A divide by zero still spends its full window but leaves HI/LO alone.
          if (pend_ok_reg) begin
            hi_next = pend_reg[63:32];
            lo_next = pend_reg[31:0];
          end
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pend_reg    <= '0;
      pend_ok_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      pend_ok_reg <= pend_ok_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  assign md.busy  = busy;
  assign md.stall = md.md_req_d & (busy | long_start);
  assign md.hi    = hi_reg;
  assign md.lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_muldiv_ctrl;

  localparam int K_BUSY  = 0;
  localparam int K_STALL = 1;
  localparam int K_HI    = 2;
  localparam int K_LO    = 3;

  typedef struct {
    string       name;
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] mon_act;
  exp_t q[$];

  muldiv_if m();

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int kind);
    case (kind)
      K_BUSY:  return {31'd0, m.busy};
      K_STALL: return {31'd0, m.stall};
      K_HI:    return m.hi;
      default: return m.lo;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        mon_act = pick(q[i].kind);
        n_checks++;
        if (q[i].cyc == cyc && mon_act === q[i].val) n_pass++;
        else $display("FAIL %s @cyc %0d (seen %0d): got %h expected %h",
                      q[i].name, q[i].cyc, cyc, mon_act, q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic push(input string nm, input int dcyc, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc + dcyc;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a long op in the current cycle and walk through its whole busy window.
  task automatic run_long(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic req, input int n,
                          input logic [31:0] nhi, input logic [31:0] nlo, input logic poke);
    $display("txn %s rs=%h rt=%h req=%0d -> hi=%h lo=%h", nm, a, b, req, nhi, nlo);
    m.md_op = op; m.rs_data = a; m.rt_data = b;
    m.md_req_d = req; m.md_cancel = 1'b0; m.md_start = 1'b1;
    push({nm, "_busy0"}, 0, K_BUSY, 32'd0);
    for (int k = 0; k <= n; k++) push($sformatf("%s_stall%0d", nm, k), k, K_STALL, {31'd0, req});
    for (int k = 1; k <= n; k++) push($sformatf("%s_busy%0d", nm, k), k, K_BUSY, 32'd1);
    push({nm, "_busy_end"}, n + 1, K_BUSY, 32'd0);
    push({nm, "_hi_early"}, n, K_HI, m_hi);
    push({nm, "_lo_early"}, n, K_LO, m_lo);
    push({nm, "_hi"}, n + 1, K_HI, nhi);
    push({nm, "_lo"}, n + 1, K_LO, nlo);
    for (int k = 1; k <= n + 1; k++) begin
      step();
      if (k == 1) m.md_start = 1'b0;
      if (poke && k == 2) begin
        m.md_op = 3'd5; m.rs_data = 32'hDEADBEEF; m.md_start = 1'b1;
      end
      if (poke && k == 3) begin
        m.md_op = 3'd0; m.md_start = 1'b0;
      end
    end
    m_hi = nhi;
    m_lo = nlo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m.md_op = 3'd0; m.md_start = 1'b0; m.md_cancel = 1'b0;
    m.rs_data = 32'd0; m.rt_data = 32'd0; m.md_req_d = 1'b0;
    step(); step();
    reset = 1'b0;
    $display("txn reset release");
    push("rst_busy", 0, K_BUSY, 32'd0);
    push("rst_stall", 0, K_STALL, 32'd0);
    push("rst_hi", 0, K_HI, 32'd0);
    push("rst_lo", 0, K_LO, 32'd0);
    step();

    run_long("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    push("mult_stall_after", 0, K_STALL, 32'd0);
    step();
    m.md_req_d = 1'b0;

    run_long("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_long("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_long("divu_zero", 3'd4, 32'd7, 32'd0, 1'b1, 10, m_hi, m_lo, 1'b0);

    $display("txn cancelled mult rs=5 rt=6");
    m.md_op = 3'd1; m.rs_data = 32'd5; m.rt_data = 32'd6;
    m.md_req_d = 1'b1; m.md_cancel = 1'b1; m.md_start = 1'b1;
    push("cancel_stall", 0, K_STALL, 32'd0);
    push("cancel_busy", 1, K_BUSY, 32'd0);
    push("cancel_hi", 1, K_HI, m_hi);
    push("cancel_lo", 1, K_LO, m_lo);
    step();
    m.md_start = 1'b0; m.md_cancel = 1'b0; m.md_req_d = 1'b0;
    n_checks++;
    if (m.busy === 1'b0) n_pass++;
    else $display("FAIL cancel_busy_direct: got %b expected 0", m.busy);
    n_checks++;
    if (m.hi === m_hi) n_pass++;
    else $display("FAIL cancel_hi_direct: got %h expected %h", m.hi, m_hi);
    step();

    $display("txn mthi 12345678 / mtlo 9abcdef0");
    m.md_op = 3'd5; m.rs_data = 32'h12345678; m.md_req_d = 1'b1; m.md_start = 1'b1;
    push("mt_stall0", 0, K_STALL, 32'd0);
    push("mt_stall1", 1, K_STALL, 32'd0);
    push("mt_busy0", 0, K_BUSY, 32'd0);
    push("mt_busy1", 1, K_BUSY, 32'd0);
    push("mt_busy2", 2, K_BUSY, 32'd0);
    push("mthi_hi", 1, K_HI, 32'h12345678);
    push("mthi_lo", 1, K_LO, m_lo);
    push("mtlo_hi", 2, K_HI, 32'h12345678);
    push("mtlo_lo", 2, K_LO, 32'h9ABCDEF0);
    step();
    m.md_op = 3'd6; m.rs_data = 32'h9ABCDEF0;
    step();
    m.md_start = 1'b0; m.md_req_d = 1'b0;
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    n_checks++;
    if (m.hi === 32'h12345678) n_pass++;
    else $display("FAIL mt_hi_direct: got %h expected 12345678", m.hi);
    n_checks++;
    if (m.lo === 32'h9ABCDEF0) n_pass++;
    else $display("FAIL mt_lo_direct: got %h expected 9abcdef0", m.lo);
    n_checks++;
    if (m.busy === 1'b0) n_pass++;
    else $display("FAIL mt_busy_direct: got %b expected 0", m.busy);
    step();

    run_long("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000, 1'b0);
    run_long("div_poke", 3'd3, 32'd7, 32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD, 1'b1);
    m.md_req_d = 1'b0;

`ifdef MULDIV_MADD_EN
    $display("txn mthi 0 / mtlo 10");
    m.md_op = 3'd5; m.rs_data = 32'd0; m.md_start = 1'b1;
    step();
    m.md_op = 3'd6; m.rs_data = 32'd10;
    step();
    m.md_start = 1'b0;
    m_hi = 32'd0; m_lo = 32'd10;
    run_long("madd", 3'd7, 32'd3, 32'hFFFFFFFC, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    m.md_req_d = 1'b0;
`else
    $display("txn op7 ignored rs=3 rt=-4");
    m.md_op = 3'd7; m.rs_data = 32'd3; m.rt_data = 32'hFFFFFFFC;
    m.md_req_d = 1'b1; m.md_start = 1'b1;
    push("op7_stall", 0, K_STALL, 32'd0);
    push("op7_busy", 1, K_BUSY, 32'd0);
    push("op7_hi", 2, K_HI, m_hi);
    push("op7_lo", 2, K_LO, m_lo);
    step();
    m.md_start = 1'b0; m.md_req_d = 1'b0;
    step();
`endif

    $display("txn op0 ignored");
    m.md_op = 3'd0; m.rs_data = 32'h55555555; m.md_req_d = 1'b1; m.md_start = 1'b1;
    push("op0_stall", 0, K_STALL, 32'd0);
    push("op0_busy", 1, K_BUSY, 32'd0);
    push("op0_hi", 1, K_HI, m_hi);
    push("op0_lo", 1, K_LO, m_lo);
    step();
    m.md_start = 1'b0; m.md_req_d = 1'b0;
    step();

    $display("txn div then reset mid-flight");
    m.md_op = 3'd3; m.rs_data = 32'd100; m.rt_data = 32'd7; m.md_start = 1'b1;
    push("rstmid_busy1", 1, K_BUSY, 32'd1);
    step();
    m.md_start = 1'b0;
    step();
    reset = 1'b1;
    push("rstmid_busy", 1, K_BUSY, 32'd0);
    push("rstmid_hi", 1, K_HI, 32'd0);
    push("rstmid_lo", 1, K_LO, 32'd0);
    push("rstmid_busy_later", 3, K_BUSY, 32'd0);
    push("rstmid_hi_later", 12, K_HI, 32'd0);
    push("rstmid_lo_later", 12, K_LO, 32'd0);
    step();
    reset = 1'b0;
    repeat (13) step();

    foreach (q[i]) begin
      n_checks++;
      $display("FAIL %s never checked: expected %h at cyc %0d", q[i].name, q[i].val, q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
